neuron_accumulator: RTL and testbench
=====================================

Name: neuron_accumulator

Overview:
- Downstream of the 8-input sign-magnitude adder tree.
- Accumulates BEATS consecutive 21-bit partial sums (8 products each) plus a per-neuron bias in two's complement.
- Applies scaling and activation, then emits one 8-bit sign-magnitude neuron output for the next layer's multipliers.
- Uses valid/ready handshakes on both sides.

Parameters:
- BEATS, 8: partial sums per neuron (neuron fan-in = 8*BEATS); legal range 1..64.
- SHIFT, 7: right shift applied to the accumulator magnitude before saturation.
- ACC_W, 28: accumulator width, two's complement; must be >= 22 + clog2(BEATS+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_sum/in_bias valid
- in_ready  out  1  block accepts a beat this cycle
- in_sum  in  21  partial sum, sign-magnitude: bit20 sign, 19:0 magnitude
- in_bias  in  21  neuron bias, sign-magnitude; sampled only on the first beat of a group
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  8  neuron output, sign-magnitude: bit7 sign, 6:0 magnitude
- busy  out  1  group in progress (state != IDLE)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=8'h00, busy=0. in_ready=1 once rst_n is released.
- Beat transfer: occurs when in_valid && in_ready.
- Output transfer: occurs when out_valid && out_ready.
- Sign-magnitude to two's complement conversion:
  - value = sign ? -mag : mag.
  - Negative zero (sign=1, mag=0) converts to 0.
- IDLE: in_ready=1.
  - On a beat: acc <= tc(in_bias) + tc(in_sum), cnt <= 1.
  - Next state is OUT if BEATS==1, else ACCUM.
- ACCUM: in_ready=1.
  - On a beat: acc <= acc + tc(in_sum), cnt <= cnt+1.
  - When the accepted beat is number BEATS-1 (0-based), go to OUT.
  - in_bias is ignored in this state.
- OUT: in_ready=0, out_valid=1.
  - out_data is registered when the final beat is accepted, so out_valid rises the cycle after the final beat (latency 1).
  - out_data stays stable while out_ready=0.
  - On transfer: out_valid <= 0, go to IDLE.
  - A new group's first beat can be accepted the cycle after the output transfer; there is no overlap.
- Activation, default (ReLU):
  - acc < 0 gives 8'h00.
  - Otherwise m = acc >> SHIFT; out = {1'b0, (m > 127) ? 7'h7F : m[6:0]}.
- Accumulator never overflows given the ACC_W rule; no wrap handling.
- in_valid gaps mid-group: state and acc hold, no timeout.
- Reset mid-group: discards the partial group; the next accepted beat is treated as beat 0 and its bias is sampled.

Optional Feature:
- Macro: NEURON_ACC_SIGNED_OUT_EN (identity activation, for the output layer).
- Defined:
  - m = |acc| >> SHIFT, saturated to 127.
  - sign = (acc < 0) && (m != 0); negative zero is never emitted.
  - out = {sign, m}.
- Undefined: ReLU as above.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package nn_pkg:
  - SM_IN_W=21, SM_OUT_W=8, MAG_MAX=7'h7F.
  - State enum {IDLE, ACCUM, OUT}.
  - Function sm_to_tc(sm, width).
- One combinational sub-module, neuron_activation (acc in, 8-bit out, SHIFT parameter, macro-dependent). It is reused by any future output-layer block.
- FSM, counter and accumulator stay in neuron_accumulator.

Test Plan:
- Nominal:
  - Stimulus: BEATS=8, SHIFT=7, bias=+0, 8 beats in_sum=+1000 (21'h003E8) back-to-back.
  - Response: acc=8000; out_valid 1 cycle after beat 8; out_data=8'h3E.
- Negative and bias:
  - Stimulus: bias=+500, 8 beats of -1000 (21'h1003E8).
  - Response: ReLU build gives 8'h00; NEURON_ACC_SIGNED_OUT_EN build gives 7500>>7=58, i.e. 8'hBA.
- Saturation:
  - Stimulus: 8 beats of +20000, bias=0.
  - Response: 160000>>7=1250; out_data=8'h7F. Signed build with -20000 beats gives 8'hFF.
- Backpressure and gaps:
  - Stimulus: in_valid toggled 1/0 mid-group; out_ready held 0 for 5 cycles.
  - Response: in_ready=0 throughout OUT; out_data stable; exactly one output transfer; next group's first beat accepted the cycle after it.
- Reset mid-group:
  - Stimulus: 3 beats accepted, pulse rst_n low asynchronously (between edges); then a fresh 8-beat group of +1000, bias=+128.
  - Response: immediate out_valid=0 and busy=0; output 8128>>7=63, i.e. 8'h3F. No contribution from the discarded beats.
- Negative zero and BEATS=1:
  - Stimulus: BEATS=1, in_sum=21'h100000, bias=21'h100000.
  - Response: out_data=8'h00 in both builds, never 8'h80.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, FSM state type and sign-magnitude helper for neuron blocks
package nn_pkg;
  localparam int SM_IN_W = 21;
  localparam int SM_OUT_W = 8;
  localparam logic [6:0] MAG_MAX = 7'h7F;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;
  // Sign-magnitude to two's complement, one bit wider than the magnitude plus sign;
  // negative zero falls out as 0 because -0 == 0.
  function automatic logic signed [SM_IN_W:0] sm_to_tc(input logic [SM_IN_W-1:0] sm);
    logic signed [SM_IN_W:0] mag;
    mag = {2'b00, sm[SM_IN_W-2:0]};
    return sm[SM_IN_W-1] ? -mag : mag;
  endfunction
endpackage

// File: rtl/neuron_activation.sv
// neuron_activation: scale and activate an accumulator into an 8-bit sign-magnitude output
// NEURON_ACC_SIGNED_OUT_EN selects identity (signed) activation; default is ReLU.
module neuron_activation import nn_pkg::*; #(
  parameter int ACC_W = 28,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic        [SM_OUT_W-1:0] out_data
);
  logic [ACC_W-1:0] mag, m;
  logic [6:0] sat;
  logic neg;
  assign neg = acc[ACC_W-1];
`ifdef NEURON_ACC_SIGNED_OUT_EN
  assign mag = neg ? -acc : acc;
`else
  assign mag = neg ? '0 : acc;
`endif
  assign m = mag >> SHIFT;
  assign sat = (m > ACC_W'(MAG_MAX)) ? MAG_MAX : m[6:0];
`ifdef NEURON_ACC_SIGNED_OUT_EN
  assign out_data = {neg && (sat != 7'd0), sat};
`else
  assign out_data = {1'b0, sat};
`endif
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: accumulate BEATS partial sums plus bias, activate, emit one neuron output
// Optional macro NEURON_ACC_SIGNED_OUT_EN (via neuron_activation) selects signed output.
module neuron_accumulator import nn_pkg::*; #(
  parameter int BEATS = 8,
  parameter int SHIFT = 7,
  parameter int ACC_W = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SM_IN_W-1:0]  in_sum,
  input  logic [SM_IN_W-1:0]  in_bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SM_OUT_W-1:0] out_data,
  output logic                busy
);
  localparam int CNT_W = $clog2(BEATS + 1);
  state_e state;
  logic signed [ACC_W-1:0] acc, acc_nxt, base;
  logic [CNT_W-1:0] cnt;
  logic [SM_OUT_W-1:0] act;
  logic beat, last;
  assign in_ready = state != OUT;
  assign busy = state != IDLE;
  assign beat = in_valid && in_ready;
  assign last = (state == IDLE) ? (BEATS == 1) : (cnt == CNT_W'(BEATS - 1));
  // first beat restarts from the bias, later beats continue the running sum
  assign base = (state == IDLE) ? ACC_W'(sm_to_tc(in_bias)) : acc;
  assign acc_nxt = base + ACC_W'(sm_to_tc(in_sum));
  neuron_activation #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_act (
    .acc(acc_nxt),
    .out_data(act)
  );
  // group FSM: accumulate beats, register the activated result on the final beat, hold until taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE, ACCUM:
          if (beat) begin
            acc <= acc_nxt;
            cnt <= (state == IDLE) ? CNT_W'(1) : cnt + 1'b1;
            state <= last ? OUT : ACCUM;
            if (last) begin
              out_valid <= 1'b1;
              out_data <= act;
            end
          end
        OUT:
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt <= '0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed checks of neuron_accumulator (BEATS=8 and BEATS=1 instances)
module tb_neuron_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv [2];
  logic ir [2];
  logic [20:0] sm [2];
  logic [20:0] bs [2];
  logic ov [2];
  logic ordy [2];
  logic [7:0] od [2];
  logic by [2];
  int total = 0;
  int fails = 0;
  int xfers = 0;
  always #5 clk = ~clk;
  neuron_accumulator #(.BEATS(8), .SHIFT(7), .ACC_W(28)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_sum(sm[0]),
    .in_bias(bs[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(by[0])
  );
  neuron_accumulator #(.BEATS(1), .SHIFT(7), .ACC_W(28)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_sum(sm[1]),
    .in_bias(bs[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(by[1])
  );
  always @(posedge clk) if (ov[0] && ordy[0]) xfers++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int d, input logic [20:0] s, input logic [20:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      iv[d] = 1'b1;
      sm[d] = s;
      bs[d] = b;
      cyc();
    end
    iv[d] = 1'b0;
  endtask
  task automatic take(input int d, input logic [7:0] exp, input string tag);
    int n = 0;
    while (!ov[d] && n < 20) begin
      cyc();
      n++;
    end
    check({tag, "_valid"}, 32'(ov[d]), 32'd1);
    check({tag, "_data"}, 32'(od[d]), 32'(exp));
    ordy[d] = 1'b1;
    cyc();
    ordy[d] = 1'b0;
    check({tag, "_valid_drop"}, 32'(ov[d]), 32'd0);
    check({tag, "_idle"}, 32'(by[d]), 32'd0);
  endtask
  initial begin
    int x0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; sm[d] = '0; bs[d] = '0; ordy[d] = 1'b0;
    end
    #12;
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data", 32'(od[0]), 32'h00);
    check("rst_busy", 32'(by[0]), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    // nominal: 8 x +1000, bias 0 -> 8000>>7 = 62
    send(0, 21'h003E8, 21'h0, 7);
    check("nom_no_early_valid", 32'(ov[0]), 32'd0);
    check("nom_busy", 32'(by[0]), 32'd1);
    send(0, 21'h003E8, 21'h0, 1);
    check("nom_latency1", 32'(ov[0]), 32'd1);
    take(0, 8'h3E, "nom");
    // negative with bias: 500 - 8000 = -7500
`ifdef NEURON_ACC_SIGNED_OUT_EN
    send(0, 21'h1003E8, 21'h001F4, 8);
    take(0, 8'hBA, "neg");
`else
    send(0, 21'h1003E8, 21'h001F4, 8);
    take(0, 8'h00, "neg");
`endif
    // saturation: 8 x +20000 -> 1250 clipped
    send(0, 21'h004E20, 21'h0, 8);
    take(0, 8'h7F, "sat_pos");
`ifdef NEURON_ACC_SIGNED_OUT_EN
    send(0, 21'h104E20, 21'h0, 8);
    take(0, 8'hFF, "sat_neg");
`else
    send(0, 21'h104E20, 21'h0, 8);
    take(0, 8'h00, "sat_neg");
`endif
    // gaps mid-group and backpressure: 8 x +1000, valid toggled
    for (int i = 0; i < 8; i++) begin
      send(0, 21'h003E8, 21'h0, 1);
      if (i < 7) begin
        cyc();
        check("gap_hold_valid", 32'(ov[0]), 32'd0);
      end
    end
    check("gap_busy", 32'(by[0]), 32'd1);
    iv[0] = 1'b1; sm[0] = 21'h007D0; bs[0] = 21'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready_low", 32'(ir[0]), 32'd0);
      check("bp_valid_held", 32'(ov[0]), 32'd1);
      check("bp_data_stable", 32'(od[0]), 32'h3E);
      cyc();
    end
    x0 = xfers;
    ordy[0] = 1'b1;
    cyc();
    ordy[0] = 1'b0;
    check("bp_one_xfer", 32'(xfers - x0), 32'd1);
    check("bp_ready_after", 32'(ir[0]), 32'd1);
    send(0, 21'h007D0, 21'h0, 8);
    take(0, 8'h7D, "next_group");
    check("bp_total_xfers", 32'(xfers - x0), 32'd2);
    // reset mid-group: 3 beats discarded, asynchronous pulse between edges
    send(0, 21'h004E20, 21'h0004F, 3);
    check("pre_rst_busy", 32'(by[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(by[0]), 32'd0);
    check("arst_valid", 32'(ov[0]), 32'd0);
    #1 rst_n = 1'b1;
    cyc();
    send(0, 21'h003E8, 21'h00080, 8);
    take(0, 8'h3F, "post_rst");
    // BEATS=1: negative zero sum and bias
    send(1, 21'h100000, 21'h100000, 1);
    take(1, 8'h00, "negzero");
`ifdef NEURON_ACC_SIGNED_OUT_EN
    send(1, 21'h1000C8, 21'h0, 1);
    take(1, 8'h81, "b1_neg200");
`else
    send(1, 21'h1000C8, 21'h0, 1);
    take(1, 8'h00, "b1_neg200");
`endif
    send(1, 21'h100064, 21'h0, 1);
    take(1, 8'h00, "b1_neg100_no_negzero");
    send(1, 21'h00064, 21'h00100, 1);
    take(1, 8'h02, "b1_bias_pos");
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
